// File: rtl/psum_ofifo_pkg.sv
// Shared constants and helpers for the psum output FIFO.
package psum_ofifo_pkg;

    localparam int unsigned COL         = 8;
    localparam int unsigned PSUM_BW     = 16;
    localparam int unsigned OFIFO_DEPTH = 64;

    // Ceiling log2 over a bounded loop so it folds to a constant at elaboration.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_ofifo_fifo_lane.sv
// Single-lane synchronous first-word-fall-through FIFO; one per output column.
module fifo_lane
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = OFIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               rd,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               overflow_pulse
);

    localparam int unsigned ptr_bw = clog2(depth);
    localparam int unsigned cnt_bw = ptr_bw + 1;

    logic [psum_bw-1:0] mem_q [depth];
    logic [ptr_bw-1:0]  wptr_q, wptr_d;
    logic [ptr_bw-1:0]  rptr_q, rptr_d;
    logic [cnt_bw-1:0]  cnt_q, cnt_d;
    logic               wr_ok;
    logic               rd_ok;

    // Flags come only from the registered count, never from wr/rd.
    assign empty          = (cnt_q == '0);
    assign full           = (cnt_q == cnt_bw'(depth));
    assign wr_ok          = wr && !full;
    assign rd_ok          = rd && !empty;
    assign overflow_pulse = wr && full;
    assign dout           = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok) wptr_d = wptr_q + ptr_bw'(1);
        if (rd_ok) rptr_d = rptr_q + ptr_bw'(1);
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + cnt_bw'(1);
            2'b01:   cnt_d = cnt_q - cnt_bw'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/psum_ofifo.sv
// Column-aligned output FIFO: per-column skewed writes, all-column pop once every lane holds data.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = OFIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [col-1:0] empty_v;
    logic [col-1:0] full_v;
    logic [col-1:0] ovf_v;
    logic           rd_acc;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    assign o_valid     = ~|empty_v;
    assign o_full      = |full_v;
    assign o_ready     = ~o_full;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
    assign rd_acc      = rd && o_valid;

    for (genvar k = 0; k < int'(col); k++) begin : g_lane
        fifo_lane #(
            .psum_bw (psum_bw),
            .depth   (depth)
        ) u_lane (
            .clk            (clk),
            .reset          (reset),
            .din            (in[k*psum_bw +: psum_bw]),
            .wr             (wr[k]),
            .rd             (rd_acc),
            .dout           (out[k*psum_bw +: psum_bw]),
            .empty          (empty_v[k]),
            .full           (full_v[k]),
            .overflow_pulse (ovf_v[k])
        );
    end

    // Sticky error flags; only reset clears them.
    always_comb begin
        overflow_d  = overflow_q | (|ovf_v);
        underflow_d = underflow_q | (rd && !o_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo: vector table, directed corner sequences, randomized run vs queue model.
module tb_psum_ofifo;

    localparam int unsigned COLS = 8;
    localparam int unsigned BW   = 16;
    localparam int unsigned DEP  = 64;
    localparam int unsigned DW   = COLS * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic [7:0]    wr;
    logic          rd;
    logic [DW-1:0] out;
    logic          o_valid, o_full, o_ready, o_overflow, o_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    psum_ofifo #(
        .col     (COLS),
        .psum_bw (BW),
        .depth   (DEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (din),
        .wr          (wr),
        .rd          (rd),
        .out         (out),
        .o_valid     (o_valid),
        .o_full      (o_full),
        .o_ready     (o_ready),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Reference: one queue per column plus sticky bits.
    logic [BW-1:0] mq [COLS][$];
    logic          m_ovf, m_unf;

    task automatic model_edge(input logic r, input logic [7:0] w, input logic rv, input logic [DW-1:0] d);
        bit all_ne;
        all_ne = 1'b1;
        if (r) begin
            for (int k = 0; k < COLS; k++) mq[k].delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        for (int k = 0; k < COLS; k++) if (mq[k].size() == 0) all_ne = 1'b0;
        for (int k = 0; k < COLS; k++) begin
            if (w[k]) begin
                if (mq[k].size() == DEP) m_ovf = 1'b1;
                else mq[k].push_back(d[k*BW +: BW]);
            end
        end
        if (rv) begin
            if (all_ne) for (int k = 0; k < COLS; k++) void'(mq[k].pop_front());
            else m_unf = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] m_out();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < COLS; k++) if (mq[k].size() > 0) r[k*BW +: BW] = mq[k][0];
        return r;
    endfunction

    function automatic logic m_valid();
        for (int k = 0; k < COLS; k++) if (mq[k].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int k = 0; k < COLS; k++) if (mq[k].size() == DEP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] rep(input int unsigned v);
        logic [BW-1:0] w;
        w = BW'(v);
        return {COLS{w}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic check_model();
        chk("model_out",       out,         m_out());
        chk("model_valid",     o_valid,     m_valid());
        chk("model_full",      o_full,      m_full());
        chk("model_ready",     o_ready,     !m_full());
        chk("model_overflow",  o_overflow,  m_ovf);
        chk("model_underflow", o_underflow, m_unf);
    endtask

    // Drive one cycle, advance the model on the edge, sample 1 time unit after.
    task automatic step(input logic r, input logic [7:0] w, input logic rv, input logic [DW-1:0] d);
        reset = r;
        wr    = w;
        rd    = rv;
        din   = d;
        @(posedge clk);
        model_edge(r, w, rv, d);
        #1;
        check_model();
    endtask

    typedef struct {
        logic          rst;
        logic [7:0]    wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_out;
        logic          exp_valid;
        logic          exp_full;
        logic          exp_ovf;
        logic          exp_unf;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [7:0] w, input logic rv, input logic [DW-1:0] d,
                                input logic [DW-1:0] eo, input logic ev, input logic ef,
                                input logic eov, input logic eun);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rv; v.din = d;
        v.exp_out = eo; v.exp_valid = ev; v.exp_full = ef; v.exp_ovf = eov; v.exp_unf = eun;
        return v;
    endfunction

    initial begin
        vec_t          tbl[$];
        logic [DW-1:0] acc;
        logic [DW-1:0] d;
        int            pw, pr;

        reset = 1'b1; wr = '0; rd = 1'b0; din = '0;
        m_ovf = 1'b0; m_unf = 1'b0;

        // Reset, idle, skewed fill, pop, underflow, reset clearing the sticky flag.
        acc = '0;
        tbl.push_back(mk(1, 8'h00, 0, '0, '0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h00, 0, '0, '0, 0, 0, 0, 0));
        for (int k = 0; k < COLS; k++) begin
            d   = DW'(16'h0100 + k) << (k * BW);
            acc = acc | d;
            tbl.push_back(mk(0, 8'(1 << k), 0, d, acc, k == COLS - 1, 0, 0, 0));
        end
        tbl.push_back(mk(0, 8'h00, 1, '0, '0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, '0, '0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, '0, '0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'hff, 1, rep(3), '0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
            chk("tbl_out",       out,         tbl[i].exp_out);
            chk("tbl_valid",     o_valid,     tbl[i].exp_valid);
            chk("tbl_full",      o_full,      tbl[i].exp_full);
            chk("tbl_ready",     o_ready,     !tbl[i].exp_full);
            chk("tbl_overflow",  o_overflow,  tbl[i].exp_ovf);
            chk("tbl_underflow", o_underflow, tbl[i].exp_unf);
        end

        // Fill to full, drop one write, drain in order.
        step(1, 8'h00, 0, '0);
        for (int i = 0; i < DEP; i++) step(0, 8'hff, 0, rep(i));
        chk("fill_full", o_full, 1'b1);
        chk("fill_ready", o_ready, 1'b0);
        chk("fill_no_ovf_yet", o_overflow, 1'b0);
        step(0, 8'hff, 0, rep(99));
        chk("drop_overflow", o_overflow, 1'b1);
        for (int i = 0; i < DEP; i++) begin
            chk("drain_out", out, rep(i));
            step(0, 8'h00, 1, '0);
        end
        chk("drain_empty", o_valid, 1'b0);
        chk("drain_out_zero", out, '0);

        // Push/pop pairs across pointer wrap.
        step(1, 8'h00, 0, '0);
        for (int i = 0; i < 100; i++) begin
            step(0, 8'hff, 0, rep(i));
            chk("wrap_out", out, rep(i));
            chk("wrap_valid", o_valid, 1'b1);
            step(0, 8'h00, 1, '0);
            chk("wrap_empty", o_valid, 1'b0);
        end
        chk("wrap_no_flags", {o_full, o_overflow, o_underflow}, '0);

        // Same-cycle read and write on a single-entry FIFO.
        step(1, 8'h00, 0, '0);
        step(0, 8'hff, 0, rep(5));
        chk("sim_pre", out, rep(5));
        step(0, 8'hff, 1, rep(6));
        chk("sim_out", out, rep(6));
        chk("sim_valid", o_valid, 1'b1);
        step(0, 8'h00, 1, '0);
        chk("sim_empty", o_valid, 1'b0);

        // Underflow, then reset mid-operation.
        step(1, 8'h00, 0, '0);
        step(0, 8'h00, 1, '0);
        chk("unf_set", o_underflow, 1'b1);
        for (int i = 1; i <= 3; i++) step(0, 8'hff, 0, rep(i));
        step(1, 8'hff, 1, rep(55));
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_unf", o_underflow, 1'b0);
        chk("rst_out", out, '0);
        step(0, 8'hff, 0, rep(7));
        chk("rst_readback", out, rep(7));

        // Randomized traffic in write-heavy, read-heavy and balanced phases.
        step(1, 8'h00, 0, '0);
        for (int c = 0; c < 3000; c++) begin
            logic [7:0]    w;
            logic          rv, r;
            logic [DW-1:0] rd_data;
            case ((c / 300) % 3)
                0:       begin pw = 90; pr = 20; end
                1:       begin pw = 20; pr = 80; end
                default: begin pw = 60; pr = 50; end
            endcase
            for (int k = 0; k < COLS; k++) w[k] = ($urandom_range(99) < pw);
            rv      = ($urandom_range(99) < pr);
            r       = ($urandom_range(999) == 0);
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            step(r, w, rv, rd_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output FIFO directly downstream of the SFP accumulate/ReLU stage.
- Captures per-column accumulated psums on per-column write strobes. Columns fill skewed in time.
- Presents a column-aligned output row to the readout/SRAM writeback controller only when every column holds data.
- Pops all columns together on a single read strobe.

Parameters:
- col, 8, number of columns (one independent FIFO lane per column)
- psum_bw, 16, bits per psum word
- depth, 64, entries per lane; power of two, at least 2
- ptr_bw, log2(depth), pointer width (derived; do not override)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  psum_bw*col  write data; lane k is bits [(k+1)*psum_bw-1 : k*psum_bw]
- wr  input  col  per-lane write strobe (driven from SFP wr_ofifo)
- rd  input  1  pop one word from every lane
- out  output  psum_bw*col  head word of each lane, same lane packing as in
- o_valid  output  1  all lanes non-empty
- o_full  output  1  any lane full
- o_ready  output  1  no lane full (inverse of o_full)
- o_overflow  output  1  sticky: a write was dropped
- o_underflow  output  1  sticky: rd asserted while o_valid was low

Behaviour:
- Reset is synchronous and active-high; one clock (clk).
- On reset: all read/write pointers and counts are 0. o_valid=0, o_full=0, o_ready=1, o_overflow=0, o_underflow=0, out=0. Memory contents are don't-care.
- Reset mid-operation discards all stored data. Writes and reads in the reset cycle are ignored.
- Lane state: wptr, rptr (ptr_bw bits, wrap modulo depth) and cnt (ptr_bw+1 bits, range 0..depth).
- empty_k = (cnt_k==0); full_k = (cnt_k==depth).
- Write, lane k:
  - If wr[k] and !full_k (registered state), store the in slice at wptr_k, increment wptr_k and cnt_k.
  - If wr[k] and full_k, drop the write and set o_overflow. This holds even if a pop occurs in the same cycle.
- Read:
  - Accepted when rd and o_valid (registered state). Every lane increments rptr and decrements cnt.
  - rd while !o_valid has no effect on any lane and sets o_underflow.
- Simultaneous accepted write and read on the same lane: cnt is unchanged, both pointers advance, and the written data is not visible at out in that cycle.
- Output timing:
  - out is first-word-fall-through, driven combinationally from mem_k[rptr_k].
  - Write-to-out latency is 1 cycle: data written at edge N appears at out and counts toward o_valid after edge N.
  - out is 0 for any empty lane.
- Flags:
  - o_valid = AND of !empty_k. o_full = OR of full_k. o_ready = !o_full.
  - All flags are combinational from registered counts, with no comb path from wr or rd.
- Pointer wrap: at depth-1 the pointer increments to 0; no bubble at wrap.
- Sticky flags clear only on reset.
- Lanes are independent: skewed fills are expected (lane k typically leads lane k+1 by one cycle). o_valid rises only once the last lane receives data.

Decomposition:
- Shared package: default COL, PSUM_BW, OFIFO_DEPTH constants, and a clog2 helper for ptr_bw.
- One sub-module, fifo_lane: single-lane synchronous FWFT FIFO with ports clk, reset, din, wr, rd, dout, empty, full, overflow_pulse.
- psum_ofifo instantiates col lanes via generate, drives every lane's rd with (rd & o_valid), and ORs the lane flags.

Test Plan:
- Reset then idle: after reset, o_valid=0, o_ready=1, o_full=0, out=0, sticky flags 0; hold 5 cycles with no stimulus and no change.
- Skewed fill: lane k writes value 16'h0100+k at cycle k (k=0..7). o_valid stays 0 until the cycle after lane 7's write, then out = {16'h0107,...,16'h0100}. A rd pops, and o_valid returns to 0 next cycle.
- Full/overflow: 64 writes of 0..63 to all lanes gives o_full=1, o_ready=0. Write 99 gives o_overflow=1 and 99 is not stored. Then 64 reads return 0..63 in order, after which o_valid=0.
- Wrap-around: perform 100 push/pop pairs with depth=64 and data equal to the index. Every out value matches its index; cnt never exceeds 1; no flag asserts.
- Simultaneous rd+wr: with one entry (5) per lane, assert rd and write 6 in the same cycle. Next cycle out=6 and o_valid=1; one further rd empties all lanes.
- Underflow and reset mid-operation: rd on empty sets o_underflow=1. Then fill 3 entries and assert reset for one cycle: o_valid=0, o_underflow=0, and a following write of 7 then reads back 7.
